mem_write_monitor: RTL and testbench

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

---
 rtl/mem_write_monitor.sv | 112 +++++++++++
 tb/tb_mem_write_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// Watches CPU stores, decides PASS/FAIL/TIMEOUT for a test run and
// logs every run-time store into a small show-ahead FIFO for the host.
module mem_write_monitor #(
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          DEPTH      = 8,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic        rd_en,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_full,
  output logic        overflow,
  output logic [15:0] wr_count,
  output logic [1:0]  status,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PASS    = 2'b01,
    FAIL    = 2'b10,
    TIMEOUT_ST = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   cycles;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic store, pop, do_push, drop;

  assign store   = memwrite && (state == RUN);
  assign pop     = rd_en && (cnt != '0);
  assign do_push = store && ((cnt != FULL_CNT) || pop);
  assign drop    = store && (cnt == FULL_CNT) && !pop;

  // A terminating store outranks the timeout on the same edge.
  always_comb begin
    state_nxt = state;
    if (state == RUN) begin
      if (memwrite && aluout == PASS_ADDR && writedata == PASS_DATA)
        state_nxt = PASS;
      else if (memwrite && aluout != ALLOW_ADDR)
        state_nxt = FAIL;
      else if (cycles == TIMEOUT - 16'd1)
        state_nxt = TIMEOUT_ST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cycles   <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN)
        cycles <= cycles + 16'd1;
      if (store && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (do_push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !do_push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wptr] <= aluout;
      mem_data[wptr] <= writedata;
    end
  end

  assign log_valid = (cnt != '0);
  assign log_full  = (cnt == FULL_CNT);
  assign log_addr  = log_valid ? mem_addr[rptr] : 32'd0;
  assign log_data  = log_valid ? mem_data[rptr] : 32'd0;
  assign status    = state;
  assign done      = (state != RUN);

endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: vector table, corner sequences and
// randomized stores checked against a queue-based reference model.
module tb_mem_write_monitor;

  localparam logic [31:0] PA = 32'd84;
  localparam logic [31:0] PD = 32'd7;
  localparam logic [31:0] AA = 32'd80;
  localparam int DEPTH = 8;
  localparam int TMO = 1000;

  logic        clk = 0;
  logic        reset = 1;
  logic        memwrite = 0;
  logic [31:0] aluout = 0;
  logic [31:0] writedata = 0;
  logic        rd_en = 0;
  logic        log_valid, log_full, overflow, done;
  logic [31:0] log_addr, log_data;
  logic [15:0] wr_count;
  logic [1:0]  status;

  mem_write_monitor dut (
    .clk(clk), .reset(reset), .memwrite(memwrite),
    .aluout(aluout), .writedata(writedata), .rd_en(rd_en),
    .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_full(log_full), .overflow(overflow), .wr_count(wr_count),
    .status(status), .done(done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // reference model state
  logic [63:0] q[$];
  int m_status, m_cyc, m_cnt;
  bit m_ovf;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  task automatic model_reset();
    q.delete();
    m_status = 0; m_cyc = 0; m_cnt = 0; m_ovf = 0;
  endtask

  task automatic model_step(input logic mw, input logic [31:0] a,
                            input logic [31:0] d, input logic r);
    int pre = q.size();
    bit pop = r && pre > 0;
    bit push = mw && m_status == 0;
    int ns = m_status;
    if (m_status == 0) begin
      if (mw && a == PA && d == PD) ns = 1;
      else if (mw && a != AA) ns = 2;
      else if (m_cyc == TMO - 1) ns = 3;
      m_cyc++;
      if (mw && m_cnt < 65535) m_cnt++;
    end
    if (pop) q.delete(0);
    if (push) begin
      if (pre < DEPTH || pop) q.push_back({a, d});
      else m_ovf = 1;
    end
    m_status = ns;
  endtask

  task automatic cmp_model();
    logic [63:0] h;
    h = (q.size() > 0) ? q[0] : 64'd0;
    chk("status", 32'(status), 32'(m_status));
    chk("done", 32'(done), 32'(m_status != 0));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("log_valid", 32'(log_valid), 32'(q.size() > 0));
    chk("log_full", 32'(log_full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("log_addr", log_addr, h[63:32]);
    chk("log_data", log_data, h[31:0]);
  endtask

  task automatic cyc(input logic mw, input logic [31:0] a,
                     input logic [31:0] d, input logic r);
    memwrite = mw; aluout = a; writedata = d; rd_en = r;
    @(posedge clk);
    model_step(mw, a, d, r);
    #1;
    cmp_model();
    @(negedge clk);
    memwrite = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    reset = 1; memwrite = 0; rd_en = 0;
    #1;
    model_reset();
    cmp_model();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    bit          rst;
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic [1:0]  st;
    logic [15:0] wc;
    logic        v;
    logic [31:0] ha;
    logic [31:0] hd;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1, 1, 80, 5, 0, 2'b00, 1, 1, 80, 5};
    vt[1]  = '{0, 1, 84, 7, 0, 2'b01, 2, 1, 80, 5};
    vt[2]  = '{0, 0, 0, 0, 1, 2'b01, 2, 1, 84, 7};
    vt[3]  = '{0, 0, 0, 0, 1, 2'b01, 2, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 1, 2'b01, 2, 0, 0, 0};
    vt[5]  = '{0, 1, 84, 7, 0, 2'b01, 2, 0, 0, 0};
    vt[6]  = '{1, 1, 84, 6, 0, 2'b10, 1, 1, 84, 6};
    vt[7]  = '{0, 1, 84, 7, 0, 2'b10, 1, 1, 84, 6};
    vt[8]  = '{0, 0, 0, 0, 1, 2'b10, 1, 0, 0, 0};
    vt[9]  = '{1, 1, 88, 3, 0, 2'b10, 1, 1, 88, 3};
    vt[10] = '{1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0};
    vt[11] = '{0, 1, 80, 9, 1, 2'b00, 1, 1, 80, 9};

    do_reset();

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      cyc(vt[i].mw, vt[i].a, vt[i].d, vt[i].rd);
      chk($sformatf("vec%0d.status", i), 32'(status), 32'(vt[i].st));
      chk($sformatf("vec%0d.wr_count", i), 32'(wr_count), 32'(vt[i].wc));
      chk($sformatf("vec%0d.valid", i), 32'(log_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d.addr", i), log_addr, vt[i].ha);
      chk($sformatf("vec%0d.data", i), log_data, vt[i].hd);
    end

    // timeout lands exactly on edge TMO
    do_reset();
    repeat (TMO - 1) cyc(0, 0, 0, 0);
    chk("tmo.before", 32'(status), 32'd0);
    cyc(0, 0, 0, 0);
    chk("tmo.edge", 32'(status), 32'd3);
    cyc(1, 84, 7, 0);
    chk("tmo.ignored", 32'(wr_count), 32'd0);

    // terminating store beats the timeout on the same edge
    do_reset();
    repeat (TMO - 1) cyc(0, 0, 0, 0);
    cyc(1, 84, 7, 0);
    chk("tmo.pass_wins", 32'(status), 32'd1);

    // fill, overflow, then push+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 80, i, 0);
    chk("ovf.full", 32'(log_full), 32'd1);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.head", log_data, 32'd0);
    cyc(1, 80, 100, 1);
    chk("ovf.still_full", 32'(log_full), 32'd1);
    chk("ovf.head2", log_data, 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] want;
      want = (i < 7) ? 32'(i + 1) : 32'd100;
      chk($sformatf("ovf.drain%0d", i), log_data, want);
      cyc(0, 0, 0, 1);
    end
    chk("ovf.empty", 32'(log_valid), 32'd0);

    // asynchronous reset from PASS, between edges
    do_reset();
    cyc(1, 84, 7, 0);
    chk("async.pass", 32'(status), 32'd1);
    #2 reset = 1;
    #1;
    chk("async.status", 32'(status), 32'd0);
    chk("async.valid", 32'(log_valid), 32'd0);
    chk("async.count", 32'(wr_count), 32'd0);
    @(negedge clk);
    do_reset();

    // randomized runs
    for (int run = 0; run < 25; run++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        logic mw, r;
        logic [31:0] a, d;
        int p;
        mw = ($urandom_range(0, 99) < 50);
        r  = ($urandom_range(0, 99) < 30);
        p  = $urandom_range(0, 99);
        a  = (p < 75) ? AA : (p < 90) ? PA : $urandom;
        d  = ($urandom_range(0, 1) == 1) ? PD : $urandom;
        cyc(mw, a, d, r);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
